// File: rtl/oldland_cache_pkg.sv
// Shared definitions for the set-associative read-only cache.
// Contents: one-hot FSM state encoding, and geometry helper functions
// that derive offset/index/tag widths from the cache parameters.
package oldland_cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_COMPARE = 3'b010,
        ST_FILL    = 3'b100
    } state_t;

    function automatic int offset_bits(input int line_size);
        return $clog2(line_size / 4);
    endfunction

    function automatic int index_bits(input int cache_size, input int line_size,
                                      input int ways);
        return $clog2(cache_size / (line_size * ways));
    endfunction

    function automatic int tag_bits(input int cache_size, input int line_size,
                                    input int ways);
        return 30 - index_bits(cache_size, line_size, ways) - offset_bits(line_size);
    endfunction

endpackage

// File: rtl/oldland_assoc_cache_if.sv
// Word-addressed read bus shared by the CPU side and the memory side.
// master: requester (drives access/addr, receives data/ack/error)
// slave : responder (receives access/addr, drives data/ack/error)
interface oldland_assoc_cache_if;
    logic        access;
    logic [29:0] addr;
    logic [31:0] data;
    logic        ack;
    logic        error;

    modport master (output access, addr, input data, ack, error);
    modport slave  (input access, addr, output data, ack, error);
endinterface

// File: rtl/oldland_cache_way.sv
// One way of the cache: data RAM (one word per entry) and tag RAM, both
// with registered (synchronous) read. The registered tag is compared
// against cmp_tag_i to produce match_o in the cycle after the read.
// Ports: clk; rd_index_i/rd_offset_i read address; cmp_tag_i compare tag;
//        rd_data_o/match_o read results; data_we_i/wr_* data write;
//        tag_we_i/wr_tag_i tag write (same index as the data write).
module oldland_cache_way #(
    parameter int INDEX_BITS  = 7,
    parameter int OFFSET_BITS = 3,
    parameter int TAG_BITS    = 20
) (
    input  logic                   clk,
    input  logic [INDEX_BITS-1:0]  rd_index_i,
    input  logic [OFFSET_BITS-1:0] rd_offset_i,
    input  logic [TAG_BITS-1:0]    cmp_tag_i,
    output logic [31:0]            rd_data_o,
    output logic                   match_o,
    input  logic                   data_we_i,
    input  logic [INDEX_BITS-1:0]  wr_index_i,
    input  logic [OFFSET_BITS-1:0] wr_offset_i,
    input  logic [31:0]            wr_data_i,
    input  logic                   tag_we_i,
    input  logic [TAG_BITS-1:0]    wr_tag_i
);
    logic [31:0]         data_mem [2**(INDEX_BITS+OFFSET_BITS)];
    logic [TAG_BITS-1:0] tag_mem  [2**INDEX_BITS];
    logic [31:0]         rd_data_q;
    logic [TAG_BITS-1:0] rd_tag_q;

    always_ff @(posedge clk) begin
        if (data_we_i)
            data_mem[{wr_index_i, wr_offset_i}] <= wr_data_i;
        if (tag_we_i)
            tag_mem[wr_index_i] <= wr_tag_i;
        rd_data_q <= data_mem[{rd_index_i, rd_offset_i}];
        rd_tag_q  <= tag_mem[rd_index_i];
    end

    assign rd_data_o = rd_data_q;
    assign match_o   = (rd_tag_q == cmp_tag_i);
endmodule

// File: rtl/oldland_assoc_cache.sv
// N-way set-associative read-only cache with round-robin replacement,
// critical-word-first wrapping line fill and per-set invalidate.
// Ports: clk, rst_n (async active-low); c_bus slave (CPU requests);
//        m_bus master (memory fills); c_inval/c_index set invalidate.
// Optional: OLDLAND_CACHE_STATS_EN adds hit_count/miss_count outputs.
module oldland_assoc_cache
    import oldland_cache_pkg::*;
#(
    parameter int CACHE_SIZE      = 8192,
    parameter int CACHE_LINE_SIZE = 32,
    parameter int NR_WAYS         = 2
) (
    input  logic clk,
    input  logic rst_n,
    oldland_assoc_cache_if.slave  c_bus,
    oldland_assoc_cache_if.master m_bus,
    input  logic c_inval,
    input  logic [index_bits(CACHE_SIZE, CACHE_LINE_SIZE, NR_WAYS)-1:0] c_index
`ifdef OLDLAND_CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int OFFSET_BITS = offset_bits(CACHE_LINE_SIZE);
    localparam int INDEX_BITS  = index_bits(CACHE_SIZE, CACHE_LINE_SIZE, NR_WAYS);
    localparam int TAG_BITS    = tag_bits(CACHE_SIZE, CACHE_LINE_SIZE, NR_WAYS);
    localparam int SETS        = CACHE_SIZE / (CACHE_LINE_SIZE * NR_WAYS);
    localparam int WAY_BITS    = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;

    state_t                 state_q;
    logic [29:0]            addr_q;
    logic [OFFSET_BITS-1:0] offset_q;
    logic [OFFSET_BITS-1:0] beats_q;
    logic                   crit_done_q;
    logic [WAY_BITS-1:0]    victim_q, victim_d, rr_q, rr_next;
    logic                   any_invalid;
    logic [SETS-1:0]        valid_q [NR_WAYS];

    logic [NR_WAYS-1:0]     way_match, way_hit, way_we;
    logic [31:0]            way_data [NR_WAYS];
    logic [31:0]            hit_data;
    logic                   hit, hit_ack, fill_ack, fill_beat, last_beat;

    wire [OFFSET_BITS-1:0] a_off = addr_q[OFFSET_BITS-1:0];
    wire [INDEX_BITS-1:0]  a_idx = addr_q[OFFSET_BITS +: INDEX_BITS];
    wire [TAG_BITS-1:0]    a_tag = addr_q[29 -: TAG_BITS];

    // RAMs are always read at the live CPU address so the result is ready
    // in COMPARE for the address latched on the same edge.
    for (genvar w = 0; w < NR_WAYS; w++) begin : g_way
        oldland_cache_way #(
            .INDEX_BITS (INDEX_BITS),
            .OFFSET_BITS(OFFSET_BITS),
            .TAG_BITS   (TAG_BITS)
        ) u_way (
            .clk        (clk),
            .rd_index_i (c_bus.addr[OFFSET_BITS +: INDEX_BITS]),
            .rd_offset_i(c_bus.addr[OFFSET_BITS-1:0]),
            .cmp_tag_i  (a_tag),
            .rd_data_o  (way_data[w]),
            .match_o    (way_match[w]),
            .data_we_i  (way_we[w]),
            .wr_index_i (a_idx),
            .wr_offset_i(offset_q),
            .wr_data_i  (m_bus.data),
            .tag_we_i   (way_we[w] && last_beat),
            .wr_tag_i   (a_tag)
        );
        assign way_hit[w] = valid_q[w][a_idx] && way_match[w];
        assign way_we[w]  = fill_beat && (victim_q == WAY_BITS'(w));
    end

    always_comb begin
        hit_data = '0;
        for (int w = 0; w < NR_WAYS; w++)
            if (way_hit[w])
                hit_data = hit_data | way_data[w];
    end

    // Lowest-numbered invalid way wins; the downward loop lets it overwrite.
    always_comb begin
        victim_d    = rr_q;
        any_invalid = 1'b0;
        for (int w = NR_WAYS - 1; w >= 0; w--)
            if (!valid_q[w][a_idx]) begin
                victim_d    = WAY_BITS'(w);
                any_invalid = 1'b1;
            end
    end

    assign rr_next   = (rr_q == WAY_BITS'(NR_WAYS - 1)) ? '0 : rr_q + 1'b1;
    assign hit       = |way_hit;
    assign hit_ack   = (state_q == ST_COMPARE) && hit;
    assign fill_ack  = (state_q == ST_FILL) && !crit_done_q && (m_bus.ack || m_bus.error);
    assign fill_beat = (state_q == ST_FILL) && m_bus.ack && !m_bus.error;
    assign last_beat = (beats_q == '0);

    assign c_bus.ack    = hit_ack || fill_ack;
    assign c_bus.error  = fill_ack && m_bus.error;
    assign c_bus.data   = hit_ack ? hit_data : (fill_ack ? m_bus.data : '0);
    assign m_bus.access = (state_q == ST_FILL);
    assign m_bus.addr   = {addr_q[29:OFFSET_BITS], offset_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            offset_q    <= '0;
            beats_q     <= '0;
            crit_done_q <= 1'b0;
            victim_q    <= '0;
            rr_q        <= '0;
            for (int w = 0; w < NR_WAYS; w++)
                valid_q[w] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (c_bus.access) begin
                        addr_q  <= c_bus.addr;
                        state_q <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (hit) begin
                        if (c_bus.access)
                            addr_q <= c_bus.addr;
                        else
                            state_q <= ST_IDLE;
                    end else begin
                        state_q     <= ST_FILL;
                        victim_q    <= victim_d;
                        offset_q    <= a_off;
                        beats_q     <= '1;
                        crit_done_q <= 1'b0;
                        // The victim is overwritten in place, so it must not
                        // hit on stale tag/partial data if the fill aborts.
                        valid_q[victim_d][a_idx] <= 1'b0;
                        if (!any_invalid)
                            rr_q <= rr_next;
                    end
                end
                ST_FILL: begin
                    if (m_bus.error) begin
                        state_q <= ST_IDLE;
                    end else if (m_bus.ack) begin
                        crit_done_q <= 1'b1;
                        offset_q    <= offset_q + 1'b1;
                        beats_q     <= beats_q - 1'b1;
                        if (last_beat) begin
                            valid_q[victim_q][a_idx] <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // Placed last so an invalidate overrides a same-cycle fill completion.
            if (c_inval)
                for (int w = 0; w < NR_WAYS; w++)
                    valid_q[w][c_index] <= 1'b0;
        end
    end

    a_single_hit: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_COMPARE) |-> $onehot0(way_hit));

`ifdef OLDLAND_CACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_q == ST_COMPARE) begin
            if (hit)
                hit_count <= hit_count + 1'b1;
            else
                miss_count <= miss_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_oldland_assoc_cache.sv
// Directed bench for oldland_assoc_cache (8 KiB, 32-byte lines, 2 ways).
module tb_oldland_assoc_cache;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       c_inval;
    logic [6:0] c_index;
    int         errors = 0;
    int         checks = 0;

    oldland_assoc_cache_if c_bus ();
    oldland_assoc_cache_if m_bus ();

`ifdef OLDLAND_CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    oldland_assoc_cache #(
        .CACHE_SIZE     (8192),
        .CACHE_LINE_SIZE(32),
        .NR_WAYS        (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .c_bus  (c_bus),
        .m_bus  (m_bus),
        .c_inval(c_inval),
        .c_index(c_index)
`ifdef OLDLAND_CACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] addr;
        bit          exp_hit;
        int          err_beat;   // 0: no error, n: m_error instead of nth ack
        bit          exp_cerr;
        bit          inval_last; // c_inval to this set with the last m_ack
    } vec_t;

    function automatic logic [31:0] memword(input logic [29:0] a);
        return {a, 2'b01} ^ 32'hA5C3_0F00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_read(input vec_t v);
        int          beat, acks, ack_cyc;
        bit          saw_m, saw_err, done;
        logic [31:0] ack_data;
        logic [2:0]  off;
        logic [29:0] exp_ma;
        beat = 0; acks = 0; ack_cyc = -1;
        saw_m = 0; saw_err = 0; done = 0; ack_data = '0;
        c_bus.addr   = v.addr;
        c_bus.access = 1'b1;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            m_bus.ack = 1'b0; m_bus.error = 1'b0; c_inval = 1'b0;
            if (acks > 0 && !m_bus.access) begin
                done = 1;
            end else begin
                if (m_bus.access) begin
                    saw_m  = 1;
                    off    = 3'(v.addr[2:0] + 3'(beat));
                    exp_ma = {v.addr[29:3], off};
                    check("m_addr", {2'b00, m_bus.addr}, {2'b00, exp_ma});
                    m_bus.data = memword(exp_ma);
                    beat++;
                    if (beat == v.err_beat) m_bus.error = 1'b1;
                    else                    m_bus.ack   = 1'b1;
                    if (v.inval_last && beat == 8) begin
                        c_inval = 1'b1;
                        c_index = v.addr[9:3];
                    end
                end
                #1;
                if (c_bus.ack) begin
                    acks++;
                    if (ack_cyc < 0) begin
                        ack_cyc  = cyc;
                        ack_data = c_bus.data;
                        saw_err  = c_bus.error;
                    end
                    c_bus.access = 1'b0;
                end
            end
        end
        c_bus.access = 1'b0;
        check("completed", 32'(done), 32'd1);
        check("ack_count", 32'(acks), 32'd1);
        check("went_to_memory", 32'(saw_m), 32'(!v.exp_hit));
        check("ack_latency", 32'(ack_cyc), v.exp_hit ? 32'd0 : 32'd1);
        check("c_error", 32'(saw_err), 32'(v.exp_cerr));
        if (!v.exp_cerr) check("c_data", ack_data, memword(v.addr));
        if (!v.exp_hit)  check("beats", 32'(beat), (v.err_beat != 0) ? 32'(v.err_beat) : 32'd8);
    endtask

    vec_t vecs [20];

    initial begin
        vecs[0]  = '{30'h103, 0, 0, 0, 0};  // cold miss, wraps 103..107,100..102
        vecs[1]  = '{30'h101, 1, 0, 0, 0};
        vecs[2]  = '{30'h000, 0, 0, 0, 0};  // set 0 -> way 0
        vecs[3]  = '{30'h400, 0, 0, 0, 0};  // set 0 -> way 1
        vecs[4]  = '{30'h800, 0, 0, 0, 0};  // evicts way 0 (0x000), rr -> 1
        vecs[5]  = '{30'h400, 1, 0, 0, 0};
        vecs[6]  = '{30'h000, 0, 0, 0, 0};  // evicts way 1 (0x400), rr -> 0
        vecs[7]  = '{30'h800, 1, 0, 0, 0};
        vecs[8]  = '{30'h400, 0, 0, 0, 0};  // evicts way 0 (0x800)
        vecs[9]  = '{30'h000, 1, 0, 0, 0};
        vecs[10] = '{30'h012, 0, 3, 0, 0};  // error after critical word
        vecs[11] = '{30'h012, 0, 0, 0, 0};
        vecs[12] = '{30'h013, 1, 0, 0, 0};
        vecs[13] = '{30'h020, 0, 1, 1, 0};  // error on first beat
        vecs[14] = '{30'h020, 0, 0, 0, 0};
        vecs[15] = '{30'h103, 1, 0, 0, 0};
        vecs[16] = '{30'h02A, 0, 0, 0, 1};  // set 5, invalidate at completion
        vecs[17] = '{30'h02A, 0, 0, 0, 0};
        vecs[18] = '{30'h02B, 1, 0, 0, 0};
        vecs[19] = '{30'h101, 1, 0, 0, 0};

        c_bus.access = 1'b0; c_bus.addr = '0;
        m_bus.ack = 1'b0; m_bus.error = 1'b0; m_bus.data = '0;
        c_inval = 1'b0; c_index = '0;
        repeat (2) @(negedge clk);
        check("rst_c_ack", 32'(c_bus.ack), 32'd0);
        check("rst_c_error", 32'(c_bus.error), 32'd0);
        check("rst_m_access", 32'(m_bus.access), 32'd0);
        check("rst_c_data", c_bus.data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 20; i++) do_read(vecs[i]);

        // Back-to-back hits: keep c_access high with a new address.
        c_bus.addr = 30'h101; c_bus.access = 1'b1;
        @(negedge clk); #1;
        check("b2b_ack0", 32'(c_bus.ack), 32'd1);
        check("b2b_data0", c_bus.data, memword(30'h101));
        c_bus.addr = 30'h105;
        @(negedge clk); #1;
        check("b2b_ack1", 32'(c_bus.ack), 32'd1);
        check("b2b_data1", c_bus.data, memword(30'h105));
        c_bus.access = 1'b0;
        @(negedge clk); #1;
        check("b2b_idle", 32'(c_bus.ack), 32'd0);
        check("b2b_no_fill", 32'(m_bus.access), 32'd0);

        // Reset in the middle of a fill.
        @(negedge clk);
        c_bus.addr = 30'h200; c_bus.access = 1'b1;
        for (int i = 0; i < 10 && !m_bus.access; i++) @(negedge clk);
        check("midfill_started", 32'(m_bus.access), 32'd1);
        m_bus.ack = 1'b1; m_bus.data = memword(30'h200);
        #1;
        if (c_bus.ack) c_bus.access = 1'b0;
        @(negedge clk);
        m_bus.data = memword(30'h201);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_m_access", 32'(m_bus.access), 32'd0);
        check("midrst_c_ack", 32'(c_bus.ack), 32'd0);
        check("midrst_c_data", c_bus.data, 32'd0);
        c_bus.access = 1'b0; m_bus.ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_read('{30'h103, 0, 0, 0, 0});
        do_read('{30'h000, 0, 0, 0, 0});
        do_read('{30'h200, 0, 0, 0, 0});
        do_read('{30'h207, 1, 0, 0, 0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/oldland_assoc_cache.md
Name: oldland_assoc_cache

Overview:
- Parametrised N-way set-associative, read-only (instruction/data-fetch) cache between the CPU fetch/load port and the memory bus.
- Successor to the direct-mapped cache: configurable associativity, round-robin victim selection, critical-word-first wrapping line fill, per-set invalidate across all ways.
- With NR_WAYS=1 it degenerates to a direct-mapped cache with critical-word-first fill.

Parameters:
- CACHE_SIZE, 8192, total data bytes; power of two.
- CACHE_LINE_SIZE, 32, bytes per line; power of two, at least 8.
- NR_WAYS, 2, associativity; power of two, 1..8.
- Derived localparams:
  - SETS = CACHE_SIZE / (CACHE_LINE_SIZE * NR_WAYS)
  - OFFSET_BITS = clog2(CACHE_LINE_SIZE / 4)
  - INDEX_BITS = clog2(SETS)
  - TAG_BITS = 30 - INDEX_BITS - OFFSET_BITS

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- c_access  in  1  CPU request; held with c_addr stable until c_ack.
- c_addr  in  30  word address.
- c_data  out  32  read data; valid while c_ack=1.
- c_ack  out  1  single-cycle completion pulse.
- c_error  out  1  single-cycle pulse alongside c_ack on a bus error.
- c_inval  in  1  invalidate set c_index in all ways, one cycle.
- c_index  in  INDEX_BITS  set to invalidate.
- m_access  out  1  memory request; held high through the whole fill.
- m_addr  out  30  memory word address.
- m_data  in  32  memory read data.
- m_ack  in  1  one word delivered per pulse.
- m_error  in  1  bus error; aborts the fill.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All valid bits cleared; victim pointer = 0; state = IDLE.
  - c_ack=0, c_error=0, m_access=0, c_data=0.
  - Tag and data RAMs are not reset.
  - Reset mid-fill: fill abandoned, m_access drops immediately, no line is validated.
- States (one-hot): IDLE, COMPARE, FILL.
  - IDLE -> COMPARE when c_access=1. Address is latched and all ways' tag/data RAMs are read (synchronous read).
  - COMPARE:
    - hit = valid[way][set] && tag[way] == latched tag, for exactly one way.
    - On hit: c_ack=1 and c_data = that way's word in the same cycle. Hit latency is 1 cycle after c_access is sampled.
    - Back-to-back hits: stay in COMPARE if c_access is still high (new address), otherwise go to IDLE.
    - On miss -> FILL.
    - Multiple matching ways is illegal; flag it with an assertion.
  - FILL:
    - Victim = the first invalid way (lowest number); otherwise the round-robin pointer.
    - The round-robin pointer increments modulo NR_WAYS only when a valid line is replaced.
    - m_access=1. m_addr = {latched tag, latched set, fill offset}.
    - Fill offset starts at the requested word and wraps modulo the line length.
    - Each m_ack writes m_data into the victim way and advances the offset.
    - c_ack pulses with c_data = m_data on the first m_ack (critical word first). The CPU is released early.
    - A new c_access while the fill is still in progress is not serviced until the fill completes.
    - After the last word's m_ack: write the tag, set valid, go to IDLE. m_access is low on the next cycle.
  - m_error in FILL:
    - c_error=1 together with c_ack if the critical word has not yet been returned. Otherwise the error is recorded only by leaving the line invalid.
    - Go to IDLE; the line remains invalid.
- Invalidate:
  - c_inval clears valid bits for set c_index in all ways.
  - If it coincides with fill completion to the same set, invalidation wins: the line ends invalid.
  - It is legal in any state.
- Tag compare and memory addresses are full 30-bit word addresses. Offset arithmetic wraps within OFFSET_BITS.

Optional Feature:
- Macro: OLDLAND_CACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0].
  - A hit increments hit_count in COMPARE; a miss increments miss_count on entry to FILL.
  - Both counters wrap and are cleared by reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package oldland_cache_pkg holds:
  - state encodings IDLE/COMPARE/FILL;
  - functions computing OFFSET_BITS, INDEX_BITS and TAG_BITS from the parameters.
- Sub-module oldland_cache_way, instantiated NR_WAYS times:
  - one way's data RAM and tag RAM, each with synchronous read;
  - write enable, and a tag-match output.
- Valid bits, victim selection and the FSM stay in the top level.

Test Plan (CACHE_SIZE=8192, LINE=32, NR_WAYS=2: 128 sets, 20-bit tag):
- Cold read of 0x0000_0103 -> m_addr sequence 0x103,0x104..0x107,0x100..0x102; c_ack with first m_data; then re-read 0x0000_0101 -> hit, c_ack 1 cycle after request, no m_access.
- Reads of 0x000_0000, 0x000_0400, 0x000_0800 (same set 0, three distinct tags) -> fills go to ways 0, 1, then way 0 (round-robin); re-read 0x000_0400 hits; 0x000_0000 misses.
- m_error asserted on the third m_ack of a fill -> no c_error (critical word already returned), the line stays invalid, and the next read of the same address refills it.
- m_error on the first beat -> c_ack=1 and c_error=1 in the same cycle; FSM returns to IDLE.
- c_inval with c_index=5 in the same cycle as the last m_ack of a set-5 fill -> subsequent read misses; other sets still hit.
- rst_n pulsed low mid-fill -> m_access, c_ack and state clear asynchronously; all previously valid lines miss after reset.
